// File: rtl/sev_seg_scan_driver.sv
// Four-digit seven-segment scan driver: time-multiplexes shadowed digit data
// onto common digit-select pins with a blanking gap between slots.
module sev_seg_scan_driver #(
   parameter int DIGIT_PERIOD_CYCLES = 50000,
   parameter int BLANK_CYCLES        = 500,
   parameter int SEG_ACTIVE_LOW      = 1,
   parameter int DIGIT_ACTIVE_LOW    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ctrl_en,
   input  logic [6:0] ctrl_digit_0,
   input  logic [6:0] ctrl_digit_1,
   input  logic [6:0] ctrl_digit_2,
   input  logic [6:0] ctrl_digit_3,
   input  logic [3:0] ctrl_dots,
   output logic [6:0] seg_out,
   output logic       dot_out,
   output logic [3:0] digit_sel,
   output logic       frame_start
);

   localparam int CW = (DIGIT_PERIOD_CYCLES > 2) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_PERIOD_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BLANK = 2'd1;
   localparam logic [1:0] SHOW  = 2'd2;
   localparam logic [1:0] SLOT_ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic DIG_INV = (DIGIT_ACTIVE_LOW != 0);

   logic [1:0]    state, state_n;
   logic [1:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          latch, fs_n;

   logic [6:0] shadow_digit [4];
   logic [3:0] shadow_dots;
   logic [6:0] ctrl_digit   [4];
   logic [6:0] digit_n      [4];
   logic [3:0] dots_n;

   logic [6:0] seg_lit;
   logic       dot_lit;
   logic [3:0] sel_on;

   always_comb begin
      ctrl_digit[0] = ctrl_digit_0;
      ctrl_digit[1] = ctrl_digit_1;
      ctrl_digit[2] = ctrl_digit_2;
      ctrl_digit[3] = ctrl_digit_3;
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      latch   = 1'b0;
      fs_n    = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en) begin
               state_n = SLOT_ENTRY;
               idx_n   = '0;
               cnt_n   = '0;
               latch   = 1'b1;
               fs_n    = 1'b1;
            end
         end
         BLANK: begin
            if (!ctrl_en) begin
               state_n = IDLE;
               idx_n   = '0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               if (cnt == BLANK_LAST) state_n = SHOW;
            end
         end
         SHOW: begin
            if (!ctrl_en) begin
               state_n = IDLE;
               idx_n   = '0;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = SLOT_ENTRY;
               cnt_n   = '0;
               idx_n   = idx + 1'b1;
               // Wrapping past digit 3 is the frame boundary: fresh snapshot.
               if (idx == 2'd3) begin
                  latch = 1'b1;
                  fs_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
         end
      endcase
   end

   // Pins are derived from next-state values so they register on the same edge.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++)
         digit_n[i] = latch ? ctrl_digit[i] : shadow_digit[i];
      dots_n  = latch ? ctrl_dots : shadow_dots;
      seg_lit = '0;
      dot_lit = 1'b0;
      sel_on  = '0;
      if (state_n == SHOW) begin
         seg_lit = digit_n[idx_n];
         dot_lit = dots_n[idx_n];
         sel_on  = 4'b0001 << idx_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         for (int unsigned i = 0; i < 4; i++) shadow_digit[i] <= '0;
         shadow_dots <= '0;
         frame_start <= 1'b0;
         seg_out     <= {7{SEG_INV}};
         dot_out     <= SEG_INV;
         digit_sel   <= {4{DIG_INV}};
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         cnt         <= cnt_n;
         for (int unsigned i = 0; i < 4; i++) shadow_digit[i] <= digit_n[i];
         shadow_dots <= dots_n;
         frame_start <= fs_n;
         seg_out     <= seg_lit ^ {7{SEG_INV}};
         dot_out     <= dot_lit ^ SEG_INV;
         digit_sel   <= sel_on ^ {4{DIG_INV}};
      end
   end

endmodule
